// File: rtl/fetch_stage_pkg.sv
// rtl/fetch_stage_pkg.sv - shared types, constants and helpers for the fetch stage
// Contents:
//   fetch_state_t   FSM encoding (BOOT, FETCH, HOLD)
//   fetch_entry_t   {instr, pc} pair held in the slot and skid registers
//   RESET_PC_DEFAULT, PC_STEP, instruction field positions
//   align_word()    clears the two byte-offset bits of an address
package fetch_stage_pkg;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_entry_t;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] PC_STEP          = 32'd4;

    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 26;
    localparam int FUNCT_MSB  = 5;
    localparam int FUNCT_LSB  = 0;

    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// rtl/fetch_stage_if.sv - instruction memory read handshake bundle
// Signals:
//   imem_ren    read request from the fetch stage
//   imem_addr   word address of the request
//   imem_rdata  read data from memory, valid with imem_ren && imem_ready
//   imem_ready  memory completes the read this cycle
// Modports: master = fetch stage side, slave = memory side.
interface fetch_stage_if;

    logic        imem_ren;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ready;

    modport master (
        output imem_ren,
        output imem_addr,
        input  imem_rdata,
        input  imem_ready
    );

    modport slave (
        input  imem_ren,
        input  imem_addr,
        output imem_rdata,
        output imem_ready
    );

endinterface

// File: rtl/fetch_slot_buffer.sv
// rtl/fetch_slot_buffer.sv - output slot plus one-entry skid register
// Ports:
//   clock, reset          clock and asynchronous active-low reset
//   flush                 invalidate slot and skid (wins over everything)
//   load_slot             write in_entry into the slot
//   load_skid             write in_entry into the skid
//   promote               move the skid entry into the slot
//   consume               downstream took the slot, nothing replaces it
//   in_entry              {instr, pc} returned by memory
//   slot_valid/slot_entry output slot contents
//   skid_valid            skid holds an entry
module fetch_slot_buffer
    import fetch_stage_pkg::*;
(
    input  logic         clock,
    input  logic         reset,
    input  logic         flush,
    input  logic         load_slot,
    input  logic         load_skid,
    input  logic         promote,
    input  logic         consume,
    input  fetch_entry_t in_entry,
    output logic         slot_valid,
    output fetch_entry_t slot_entry,
    output logic         skid_valid
);

    fetch_entry_t skid_entry;

    // Slot: flush invalidates but leaves the data fields alone, so a
    // flushed instruction simply stops being presented as valid.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            slot_valid <= 1'b0;
            slot_entry <= '0;
        end else if (flush) begin
            slot_valid <= 1'b0;
        end else if (promote) begin
            slot_valid <= 1'b1;
            slot_entry <= skid_entry;
        end else if (load_slot) begin
            slot_valid <= 1'b1;
            slot_entry <= in_entry;
        end else if (consume) begin
            slot_valid <= 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            skid_valid <= 1'b0;
            skid_entry <= '0;
        end else if (flush) begin
            skid_valid <= 1'b0;
        end else if (promote) begin
            skid_valid <= 1'b0;
        end else if (load_skid) begin
            skid_valid <= 1'b1;
            skid_entry <= in_entry;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage with PC, stall, redirect and skid buffer
// Ports:
//   clock, reset     system clock, asynchronous active-low reset
//   stall            downstream cannot accept the slot this cycle
//   redirect         taken branch/jump: load redirect_pc and flush
//   redirect_pc      redirect target (low two bits dropped)
//   imem             instruction memory read handshake (master side)
//   instr_valid      output slot holds an instruction
//   instr, instr_pc  slot instruction word and its address
//   opcode, funct    instruction fields for the decoders
//   misalign_err     one-cycle pulse after a redirect with a non-word target
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 stall,
    input  logic                 redirect,
    input  logic [31:0]          redirect_pc,
    fetch_stage_if.master        imem,
    output logic                 instr_valid,
    output logic [31:0]          instr,
    output logic [31:0]          instr_pc,
    output logic [5:0]           opcode,
    output logic [5:0]           funct,
    output logic                 misalign_err
);

    fetch_state_t state, state_next;
    logic [31:0]  pc, pc_next;
    logic         misalign_next;

    logic         slot_free;
    logic         flush;
    logic         load_slot;
    logic         load_skid;
    logic         promote;
    logic         consume;
    logic         skid_valid;
    fetch_entry_t slot_entry;
    fetch_entry_t mem_entry;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= BOOT;
            pc           <= RESET_PC;
            misalign_err <= 1'b0;
        end else begin
            state        <= state_next;
            pc           <= pc_next;
            misalign_err <= misalign_next;
        end
    end

    always_comb begin
        state_next    = state;
        pc_next       = pc;
        flush         = 1'b0;
        load_slot     = 1'b0;
        load_skid     = 1'b0;
        promote       = 1'b0;
        consume       = 1'b0;
        misalign_next = redirect && (redirect_pc[1:0] != 2'b00);
        slot_free     = !instr_valid || !stall;

        unique case (state)
            BOOT: begin
                state_next = FETCH;
                if (redirect) begin
                    pc_next = align_word(redirect_pc);
                end
            end

            FETCH: begin
                if (redirect) begin
                    // Any data returned this cycle belongs to the old path.
                    flush   = 1'b1;
                    pc_next = align_word(redirect_pc);
                end else if (imem.imem_ready) begin
                    pc_next = pc + PC_STEP;
                    if (slot_free) begin
                        load_slot = 1'b1;
                    end else begin
                        // Slot is blocked but the read already completed:
                        // park it in the skid and stop requesting.
                        load_skid  = 1'b1;
                        state_next = HOLD;
                    end
                end else begin
                    // Request stays up with a stable address; the slot may
                    // still drain underneath it.
                    consume = instr_valid && !stall;
                end
            end

            HOLD: begin
                if (redirect) begin
                    flush      = 1'b1;
                    pc_next    = align_word(redirect_pc);
                    state_next = FETCH;
                end else if (!stall) begin
                    promote    = skid_valid;
                    state_next = FETCH;
                end
            end

            default: begin
                state_next = BOOT;
            end
        endcase
    end

    assign imem.imem_ren  = (state == FETCH);
    assign imem.imem_addr = pc;

    assign mem_entry.instr = imem.imem_rdata;
    assign mem_entry.pc    = pc;

    fetch_slot_buffer u_slot_buffer (
        .clock      (clock),
        .reset      (reset),
        .flush      (flush),
        .load_slot  (load_slot),
        .load_skid  (load_skid),
        .promote    (promote),
        .consume    (consume),
        .in_entry   (mem_entry),
        .slot_valid (instr_valid),
        .slot_entry (slot_entry),
        .skid_valid (skid_valid)
    );

    assign instr    = slot_entry.instr;
    assign instr_pc = slot_entry.pc;
    assign opcode   = slot_entry.instr[OPCODE_MSB:OPCODE_LSB];
    assign funct    = slot_entry.instr[FUNCT_MSB:FUNCT_LSB];

endmodule
